// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the direct-mapped data cache.
// The cache connects to the slave modport; the CPU/memory environment connects to the master modport.
interface data_cache_if;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        output READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        input  READDATA, BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4 bytes.
// Hits resolve combinationally in IDLE; misses walk WRITE_BACK -> MEM_READ -> UPDATE.
module data_cache (
    input  logic          CLK,
    input  logic          RESET,
    data_cache_if.slave   bus
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WRITE_BACK = 2'd1;
    localparam logic [1:0] MEM_READ   = 2'd2;
    localparam logic [1:0] UPDATE     = 2'd3;

    logic [1:0]  state;
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tags  [8];
    logic [31:0] lines [8];

    logic [2:0]  index;
    logic [2:0]  tag;
    logic [1:0]  offset;
    logic        request;
    logic        hit;

    assign index   = bus.ADDRESS[4:2];
    assign tag     = bus.ADDRESS[7:5];
    assign offset  = bus.ADDRESS[1:0];
    assign request = bus.READ || bus.WRITE;
    assign hit     = valid[index] && (tags[index] == tag);

    assign bus.BUSYWAIT      = request && !((state == IDLE) && hit);
    assign bus.READDATA      = lines[index][{offset, 3'b000} +: 8];
    assign bus.mem_read      = (state == MEM_READ);
    assign bus.mem_write     = (state == WRITE_BACK);
    assign bus.mem_writedata = lines[index];

    // The CPU holds ADDRESS while stalled, so both addresses stay stable per transfer.
    always_comb begin
        if (state == WRITE_BACK)
            bus.mem_address = {tags[index], index};
        else
            bus.mem_address = {tag, index};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request && hit) begin
                        if (bus.WRITE) begin
                            lines[index][{offset, 3'b000} +: 8] <= bus.WRITEDATA;
                            dirty[index] <= 1'b1;
                        end
                    end else if (request) begin
                        if (valid[index] && dirty[index])
                            state <= WRITE_BACK;
                        else
                            state <= MEM_READ;
                    end
                end
                WRITE_BACK: begin
                    if (!bus.mem_busywait)
                        state <= MEM_READ;
                end
                MEM_READ: begin
                    if (!bus.mem_busywait)
                        state <= UPDATE;
                end
                UPDATE: begin
                    lines[index] <= bus.mem_readdata;
                    tags[index]  <= tag;
                    valid[index] <= 1'b1;
                    dirty[index] <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a block memory that stays busy for 3 cycles per transfer.
module tb_data_cache;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    data_cache_if bus ();

    data_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [64];
    logic [1:0]  mcnt = '0;

    assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (mcnt != 2'd3);
    assign bus.mem_readdata = mem[bus.mem_address];

    always @(posedge CLK) begin
        if (!(bus.mem_read || bus.mem_write) || mcnt == 2'd3) begin
            if (bus.mem_write && mcnt == 2'd3)
                mem[bus.mem_address] <= bus.mem_writedata;
            mcnt <= '0;
        end else begin
            mcnt <= mcnt + 2'd1;
        end
    end

    // Transfer monitor: counts cycles each request is seen and records the last addresses/data.
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    logic [5:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [5:0]  rd_addr = '0;

    always @(negedge CLK) begin
        if (bus.mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            wb_addr <= bus.mem_address;
            wb_data <= bus.mem_writedata;
        end
        if (bus.mem_read) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= bus.mem_address;
        end
        if (bus.mem_read && bus.mem_write)
            both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one CPU request and holds it until BUSYWAIT falls at a negedge.
    task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata, output int stalls);
        bit done = 0;
        @(posedge CLK); #1;
        bus.READ = rd; bus.WRITE = wr; bus.ADDRESS = addr; bus.WRITEDATA = wdata;
        stalls = 0;
        rdata  = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (!bus.BUSYWAIT) begin
                done  = 1;
                rdata = bus.READDATA;
                break;
            end
            stalls++;
        end
        check("req_timeout", {31'd0, done}, 32'd1);
        @(posedge CLK); #1;
        bus.READ = 1'b0; bus.WRITE = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    logic [7:0] rdata;
    int         stalls;
    int         wr0, rd0;

    initial begin
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'(i);
            mem[i] = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        end
        mem[1] = 32'hDDCC_BBAA;
        mem[9] = 32'h4433_2211;

        RESET = 1'b1;
        bus.READ = 1'b0; bus.WRITE = 1'b0; bus.ADDRESS = '0; bus.WRITEDATA = '0;
        do_reset();
        @(negedge CLK);
        check("rst_mem_read",  {31'd0, bus.mem_read},  32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_busywait",  {31'd0, bus.BUSYWAIT},  32'd0);

        // Cold read miss with explicit cycle-level look at the fetch request
        @(posedge CLK); #1;
        bus.READ = 1'b1; bus.ADDRESS = 8'h05;
        @(negedge CLK);
        check("miss_busy", {31'd0, bus.BUSYWAIT}, 32'd1);
        @(negedge CLK);
        check("miss_mem_read", {31'd0, bus.mem_read}, 32'd1);
        check("miss_mem_addr", {26'd0, bus.mem_address}, 32'h01);
        check("miss_no_write", {31'd0, bus.mem_write}, 32'd0);
        do_req(1'b1, 1'b0, 8'h05, 8'h00, rdata, stalls);
        check("miss_rdata", {24'd0, rdata}, 32'hBB);
        check("miss_wr_cnt", wr_cnt, 0);

        // Write hit then read-back, no stalls
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 1'b1, 8'h06, 8'h5A, rdata, stalls);
        check("wr_hit_stalls", stalls, 0);
        do_req(1'b1, 1'b0, 8'h06, 8'h00, rdata, stalls);
        check("rd_hit_stalls", stalls, 0);
        check("rd_hit_data", {24'd0, rdata}, 32'h5A);
        check("hit_no_mem", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

        // Dirty conflict miss: write-back then fetch
        wr0 = wr_cnt;
        do_req(1'b1, 1'b0, 8'h25, 8'h00, rdata, stalls);
        check("evict_stalls", stalls, 10);
        check("evict_wr_seen", wr_cnt - wr0, 4);
        check("evict_wb_addr", {26'd0, wb_addr}, 32'h01);
        check("evict_wb_data", wb_data, 32'hDD5A_BBAA);
        check("evict_rd_addr", {26'd0, rd_addr}, 32'h09);
        check("evict_rdata", {24'd0, rdata}, 32'h22);
        check("evict_mem1", mem[1], 32'hDD5A_BBAA);

        // Reset while MEM_READ is in flight
        @(posedge CLK); #1;
        bus.READ = 1'b1; bus.ADDRESS = 8'h10;
        @(posedge CLK);
        @(negedge CLK);
        check("rstmr_mem_read", {31'd0, bus.mem_read}, 32'd1);
        RESET = 1'b1; bus.READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rstmr_mem_read_low", {31'd0, bus.mem_read}, 32'd0);
        check("rstmr_busywait", {31'd0, bus.BUSYWAIT}, 32'd0);
        rd0 = rd_cnt;
        do_req(1'b1, 1'b0, 8'h10, 8'h00, rdata, stalls);
        check("rstmr_remiss", rd_cnt - rd0, 4);
        check("rstmr_rdata", {24'd0, rdata}, 32'h04);

        // READ and WRITE together on a hit act as a write
        do_req(1'b1, 1'b0, 8'h04, 8'h00, rdata, stalls);
        check("rw_fill_rdata", {24'd0, rdata}, 32'hAA);
        do_req(1'b1, 1'b1, 8'h04, 8'h11, rdata, stalls);
        check("rw_stalls", stalls, 0);
        do_req(1'b1, 1'b0, 8'h04, 8'h00, rdata, stalls);
        check("rw_readback", {24'd0, rdata}, 32'h11);
        wr0 = wr_cnt;
        do_req(1'b1, 1'b0, 8'h24, 8'h00, rdata, stalls);
        check("rw_evict_seen", wr_cnt - wr0, 4);
        check("rw_evict_data", wb_data, 32'hDD5A_BB11);
        check("rw_evict_rdata", {24'd0, rdata}, 32'h11);

        // Conflict miss on a clean valid line: fetch only
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(1'b1, 1'b0, 8'h05, 8'h00, rdata, stalls);
        check("clean_no_write", wr_cnt - wr0, 0);
        check("clean_rd_seen", rd_cnt - rd0, 4);
        check("clean_stalls", stalls, 6);
        check("clean_rdata", {24'd0, rdata}, 32'hBB);

        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
